// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    // Default unit count and op-code width; op code n selects unit n.
    localparam int ALU_NUM_UNITS = 8;
    localparam int ALU_OP_W      = 3;

    // Units 0..3 are single-cycle; units 4..7 report completion via done.
    localparam logic [7:0] ALU_FIXED_LAT_MASK = 8'h0F;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_NOT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of request, unit-side and response signals of the ALU issue controller.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports (signals): req_valid/req_ready/req_op/req_a/req_b, op_a/op_b/start_vec,
//   unit_done/unit_res, rsp_valid/rsp_ready/rsp_res/rsp_op/rsp_err.
// Modports: master = the controller, slave = requester, units and consumer.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int NUM_UNITS = ALU_NUM_UNITS,
    parameter int OP_W      = ALU_OP_W
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic [OP_W-1:0]        req_op;
    logic [7:0]             req_a;
    logic [7:0]             req_b;

    logic [7:0]             op_a;
    logic [7:0]             op_b;
    logic [NUM_UNITS-1:0]   start_vec;
    logic [NUM_UNITS-1:0]   unit_done;
    logic [NUM_UNITS*16-1:0] unit_res;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [15:0]            rsp_res;
    logic [OP_W-1:0]        rsp_op;
    logic                   rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b, unit_done, unit_res, rsp_ready,
        output req_ready, op_a, op_b, start_vec, rsp_valid, rsp_res, rsp_op, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, unit_done, unit_res, rsp_ready,
        input  req_ready, op_a, op_b, start_vec, rsp_valid, rsp_res, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_res_mux.sv
// Selects one unit's 16-bit result out of the flattened result bus.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (unit index), res_in (NUM_UNITS x 16 flattened), res_out (selected result, 0 if sel out of range).
module alu_res_mux #(
    parameter int NUM_UNITS = 8,
    parameter int OP_W      = 3
) (
    input  logic [OP_W-1:0]          sel,
    input  logic [NUM_UNITS*16-1:0]  res_in,
    output logic [15:0]              res_out
);

    always_comb begin
        res_out = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel == OP_W'(i)) begin
                res_out = res_in[i*16 +: 16];
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequences one ALU op at a time: accept, start pulse to the unit, collect result, return it.
// Latency: accept->rsp_valid 3 cycles for fixed units, done+1 for variable units, 1 for illegal ops.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready, then IDLE for one cycle.
// Ports: clk, rst_n (async active-low), bus (alu_issue_ctrl_if.master).
// Optional: ALU_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles for variable-latency units.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int                   NUM_UNITS      = ALU_NUM_UNITS,
    parameter int                   OP_W           = ALU_OP_W,
    parameter logic [NUM_UNITS-1:0] FIXED_LAT_MASK = NUM_UNITS'(ALU_FIXED_LAT_MASK)
`ifdef ALU_TIMEOUT_EN
    ,
    parameter int                   TIMEOUT        = 64
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.master bus
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]           state;
    logic [OP_W-1:0]      op_q;
    logic [7:0]           a_q;
    logic [7:0]           b_q;
    logic [15:0]          res_q;
    logic                 err_q;

    logic [NUM_UNITS-1:0] op_hot;
    logic                 op_fixed;
    logic                 op_done;
    logic                 op_illegal;
    logic [15:0]          mux_res;

    // One-hot of the latched op; all-zero when the op is out of range.
    always_comb begin
        op_hot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            op_hot[i] = (op_q == OP_W'(i));
        end
    end

    // Done strobes of units other than the selected one are masked off here.
    assign op_fixed   = |(FIXED_LAT_MASK & op_hot);
    assign op_done    = |(bus.unit_done & op_hot);
    assign op_illegal = ({1'b0, bus.req_op} >= (OP_W+1)'(NUM_UNITS));

    alu_res_mux #(
        .NUM_UNITS (NUM_UNITS),
        .OP_W      (OP_W)
    ) u_res_mux (
        .sel     (op_q),
        .res_in  (bus.unit_res),
        .res_out (mux_res)
    );

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;
    // wait_cnt holds the number of WAIT cycles already completed.
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                        if (op_illegal) begin
                            res_q <= '0;
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef ALU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // Fixed units registered their result on the start edge,
                    // so it is already on unit_res in the first WAIT cycle.
                    // Done is checked before the watchdog so it wins a tie.
                    if (op_fixed || op_done) begin
                        res_q <= mux_res;
                        err_q <= 1'b0;
                        state <= RESP;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (wait_expired) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and start outputs decode straight from state so an
    // asynchronous reset drops them without waiting for a clock.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.start_vec = (state == ISSUE) ? op_hot : '0;
    assign bus.op_a      = a_q;
    assign bus.op_b      = b_q;
    assign bus.rsp_res   = res_q;
    assign bus.rsp_op    = op_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, random ops vs reference, corner sequences.
// Latency: not applicable.
// Backpressure: exercised through rsp_ready holds.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.NUM_UNITS(8), .OP_W(3)) bus ();
    alu_issue_ctrl_if #(.NUM_UNITS(6), .OP_W(3)) bus6 ();

    alu_issue_ctrl #(
        .NUM_UNITS      (8),
        .OP_W           (3),
        .FIXED_LAT_MASK (8'h0F)
`ifdef ALU_TIMEOUT_EN
        ,
        .TIMEOUT        (16)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_issue_ctrl #(
        .NUM_UNITS      (6),
        .OP_W           (3),
        .FIXED_LAT_MASK (6'h0F)
`ifdef ALU_TIMEOUT_EN
        ,
        .TIMEOUT        (16)
`endif
    ) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    assign bus6.unit_done = '0;
    assign bus6.unit_res  = '0;

    // ---------------- unit behaviour (what the execution units compute) ----------------
    function automatic logic [15:0] unit_fn(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0: return {8'h00, a & b};
            1: return {8'h00, a | b};
            2: return {8'h00, a ^ b};
            3: return 16'(a) + 16'(b);
            4: return {8'h00, 8'(a - b)};
            5: return 16'(a) * 16'(b);
            6: return (b == 8'h00) ? 16'hFFFF : 16'(a / b);
            7: return {8'h00, ~a};
            default: return 16'h0000;
        endcase
    endfunction

    int          var_delay  = 1;   // done appears var_delay cycles after the start cycle
    bit          done_en    = 1'b1;
    logic [7:0]  noise_done = 8'h00;
    logic        pend_act   = 1'b0;
    logic [2:0]  pend_unit  = 3'd0;
    int          pend_cnt   = 0;
    logic [15:0] pend_res   = 16'h0;
    logic [15:0] fix_res [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic        done_now;

    always @(posedge clk) begin
        if (pend_act) begin
            if (pend_cnt == 0) pend_act <= 1'b0;
            else               pend_cnt <= pend_cnt - 1;
        end
        for (int n = 0; n < 8; n++) begin
            if (bus.start_vec[n]) begin
                if (n < 4) begin
                    fix_res[n] <= unit_fn(n, bus.op_a, bus.op_b);
                end else begin
                    pend_act  <= 1'b1;
                    pend_unit <= 3'(n);
                    pend_cnt  <= var_delay - 1;
                    pend_res  <= unit_fn(n, bus.op_a, bus.op_b);
                end
            end
        end
    end

    always_comb begin
        done_now      = pend_act && (pend_cnt == 0) && done_en;
        bus.unit_done = noise_done;
        if (done_now) bus.unit_done[pend_unit] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n < 4)
                bus.unit_res[n*16 +: 16] = fix_res[n];
            else if (done_now && pend_unit == 3'(n))
                bus.unit_res[n*16 +: 16] = pend_res;
            else
                bus.unit_res[n*16 +: 16] = 16'hBAD0 | 16'(n);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int dly, input int hold,
                           output logic [15:0] res, output logic [2:0] rop, output logic err,
                           output int lat, output int nstart, output logic [7:0] svec);
        int guard;
        @(negedge clk);
        var_delay     = dly;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = (hold == 0);
        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nstart = 0; svec = 8'h00;
        do begin
            @(negedge clk);
            lat++;
            if (bus.start_vec != 8'h00) begin
                nstart++;
                svec = bus.start_vec;
            end
        end while (!bus.rsp_valid && lat < 200);
        res = bus.rsp_res;
        rop = bus.rsp_op;
        err = bus.rsp_err;
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          dly;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t        tbl [9];
    logic [15:0] r_res;
    logic [2:0]  r_op;
    logic        r_err;
    int          r_lat, r_ns;
    logic [7:0]  r_sv;
    logic [7:0]  one8;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.req_valid  = 1'b0; bus.req_op  = 3'd0; bus.req_a  = 8'h00; bus.req_b  = 8'h00; bus.rsp_ready  = 1'b1;
        bus6.req_valid = 1'b0; bus6.req_op = 3'd0; bus6.req_a = 8'h00; bus6.req_b = 8'h00; bus6.rsp_ready = 1'b1;
        one8 = 8'h01;

        tbl[0] = '{OP_AND, 8'hF0, 8'h3C, 1, 16'h0030, 3};
        tbl[1] = '{OP_OR,  8'h0F, 8'hF0, 1, 16'h00FF, 3};
        tbl[2] = '{OP_XOR, 8'hAA, 8'hFF, 1, 16'h0055, 3};
        tbl[3] = '{OP_ADD, 8'hFF, 8'h01, 1, 16'h0100, 3};
        tbl[4] = '{OP_SUB, 8'h05, 8'h03, 2, 16'h0002, 4};
        tbl[5] = '{OP_MUL, 8'd12, 8'd13, 8, 16'd156,  10};
        tbl[6] = '{OP_DIV, 8'd100, 8'd7, 3, 16'h000E, 5};
        tbl[7] = '{OP_NOT, 8'h5A, 8'h00, 1, 16'h00A5, 3};
        tbl[8] = '{OP_MUL, 8'hFF, 8'hFF, 4, 16'hFE01, 6};

        // ---- reset values ----
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_start_vec", 32'(bus.start_vec), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_op_a",      32'(bus.op_a),      32'd0);
        chk("rst_op_b",      32'(bus.op_b),      32'd0);
        chk("rst_rsp_res",   32'(bus.rsp_res),   32'd0);
        chk("rst_rsp_op",    32'(bus.rsp_op),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- vector table ----
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dly, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
            chk($sformatf("tbl%0d_res", i),    32'(r_res), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_err", i),    32'(r_err), 32'd0);
            chk($sformatf("tbl%0d_op", i),     32'(r_op),  32'(tbl[i].op));
            chk($sformatf("tbl%0d_lat", i),    32'(r_lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_nstart", i), 32'(r_ns),  32'd1);
            chk($sformatf("tbl%0d_start", i),  32'(r_sv),  32'(one8 << tbl[i].op));
        end

        // ---- randomized ops against reference model ----
        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            int dly, hold, exp_lat;
            op   = 3'($urandom_range(0, 7));
            a    = 8'($urandom);
            b    = 8'($urandom);
            dly  = $urandom_range(1, 12);
            hold = $urandom_range(0, 3);
            noise_done = 8'($urandom) & ~(one8 << op);
            exp_lat = (op < 4) ? 3 : dly + 2;
            run_txn(op, a, b, dly, hold, r_res, r_op, r_err, r_lat, r_ns, r_sv);
            chk($sformatf("rnd%0d_res", i), 32'(r_res), 32'(unit_fn(op, a, b)));
            chk($sformatf("rnd%0d_err", i), 32'(r_err), 32'd0);
            chk($sformatf("rnd%0d_lat", i), 32'(r_lat), 32'(exp_lat));
            chk($sformatf("rnd%0d_start", i), 32'(r_sv), 32'(one8 << op));
        end
        noise_done = 8'h00;

        // ---- backpressure with a held follow-up request ----
        begin
            int guard;
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_op = OP_XOR; bus.req_a = 8'h0F; bus.req_b = 8'h33;
            bus.rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            bus.req_op = OP_ADD; bus.req_a = 8'h01; bus.req_b = 8'h02;  // held request
            guard = 0;
            do begin @(negedge clk); guard++; end while (!bus.rsp_valid && guard < 50);
            chk("bp_op_a_stable", 32'(bus.op_a), 32'h0F);
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("bp%0d_res", i),   32'(bus.rsp_res),   32'h003C);
                chk($sformatf("bp%0d_op", i),    32'(bus.rsp_op),    32'd2);
                chk($sformatf("bp%0d_rdy", i),   32'(bus.req_ready), 32'd0);
                chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
                @(negedge clk);
            end
            bus.rsp_ready = 1'b1;
            chk("bp_hs_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
            chk("bp_after_ready", 32'(bus.req_ready), 32'd1);
            chk("bp_after_start", 32'(bus.start_vec), 32'd0);
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            @(negedge clk);
            chk("bp_next_start", 32'(bus.start_vec), 32'h08);
            guard = 0;
            do begin @(negedge clk); guard++; end while (!bus.rsp_valid && guard < 50);
            chk("bp_next_res", 32'(bus.rsp_res), 32'h0003);
            chk("bp_next_op",  32'(bus.rsp_op),  32'd3);
            @(posedge clk);
            #1;
        end

        // ---- illegal op on a 6-unit controller ----
        begin
            int sbad;
            @(negedge clk);
            bus6.req_valid = 1'b1; bus6.req_op = 3'd7; bus6.req_a = 8'h11; bus6.req_b = 8'h22;
            bus6.rsp_ready = 1'b0;
            @(posedge clk);
            #1 bus6.req_valid = 1'b0;
            @(negedge clk);
            chk("ill_valid", 32'(bus6.rsp_valid), 32'd1);
            chk("ill_res",   32'(bus6.rsp_res),   32'd0);
            chk("ill_err",   32'(bus6.rsp_err),   32'd1);
            chk("ill_op",    32'(bus6.rsp_op),    32'd7);
            sbad = 0;
            repeat (2) begin
                if (bus6.start_vec != 6'h00) sbad++;
                @(negedge clk);
            end
            chk("ill_no_start", 32'(sbad), 32'd0);
            bus6.rsp_ready = 1'b1;
            @(negedge clk);
            chk("ill_after_valid", 32'(bus6.rsp_valid), 32'd0);
            chk("ill_after_err",   32'(bus6.rsp_err),   32'd0);
            chk("ill_after_ready", 32'(bus6.req_ready), 32'd1);
        end

        // ---- reset in the middle of a DIV wait ----
        begin
            int bad_cycles;
            @(negedge clk);
            var_delay = 12;
            bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_a = 8'd200; bus.req_b = 8'd9;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_start", 32'(bus.start_vec), 32'd0);
            chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
            chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
            @(negedge clk);
            rst_n = 1'b1;
            bad_cycles = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.rsp_valid || !bus.req_ready || bus.start_vec != 8'h00) bad_cycles++;
            end
            chk("stray_done_ignored", 32'(bad_cycles), 32'd0);
            run_txn(OP_DIV, 8'd200, 8'd9, 5, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
            chk("post_rst_res", 32'(r_res), 32'd22);
            chk("post_rst_lat", 32'(r_lat), 32'd7);
        end

`ifdef ALU_TIMEOUT_EN
        // ---- watchdog ----
        done_en = 1'b0;
        run_txn(OP_SUB, 8'd9, 8'd4, 1, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_res", 32'(r_res), 32'd0);
        chk("to_lat", 32'(r_lat), 32'd18);
        done_en = 1'b1;
        run_txn(OP_SUB, 8'd9, 8'd4, 16, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
        chk("to_tie_err", 32'(r_err), 32'd0);
        chk("to_tie_res", 32'(r_res), 32'h0005);
        chk("to_tie_lat", 32'(r_lat), 32'd18);
        run_txn(OP_MUL, 8'd3, 8'd5, 17, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
        chk("to_late_err", 32'(r_err), 32'd1);
        chk("to_late_res", 32'(r_res), 32'd0);
        repeat (3) @(negedge clk);
        run_txn(OP_ADD, 8'd3, 8'd5, 1, 0, r_res, r_op, r_err, r_lat, r_ns, r_sv);
        chk("to_fixed_res", 32'(r_res), 32'd8);
        chk("to_fixed_err", 32'(r_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
